// File: rtl/spi_pkg.sv
// spi_pkg: shared types, widths and bit-order helpers for the SPI slave
package spi_pkg;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    // indexed by {cpol, cpha}: 1 = sample on rising sclk (shift on falling), 0 = the reverse
    localparam logic [3:0] SAMPLE_ON_RISE = 4'b1001;

    function automatic logic first_bit(input logic [DATA_W-1:0] d, input logic lsbfe);
        return lsbfe ? d[0] : d[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] drop_bit(input logic [DATA_W-1:0] d, input logic lsbfe);
        return lsbfe ? d >> 1 : d << 1;
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] d, input logic b, input logic lsbfe);
        return lsbfe ? {b, d[DATA_W-1:1]} : {d[DATA_W-2:0], b};
    endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer plus edge detector for one async input
//   PCLK, PRESET_n  clock, async active-low reset
//   idle            value the synchronizer resets to
//   din             asynchronous input
//   level           synchronized level
//   changed         one-cycle pulse on any edge; level then tells rise (1) from fall (0)
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic PCLK,
    input  logic PRESET_n,
    input  logic idle,
    input  logic din,
    output logic level,
    output logic changed
);
    logic [STAGES-1:0] sync;
    logic              dly;

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            sync <= {STAGES{idle}};
            dly  <= idle;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            dly  <= sync[STAGES-1];
        end
    end

    assign level   = sync[STAGES-1];
    assign changed = sync[STAGES-1] ^ dly;
endmodule

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave byte engine, modes 0-3, MSB/LSB first, in the PCLK domain
//   PCLK, PRESET_n                    clock, async active-low reset
//   sclk_i, ss_i, mosi_i, miso_o      SPI bus (inputs asynchronous to PCLK)
//   cpol_i, cpha_i, lsbfe_i           mode and bit order, changed only while idle
//   tx_data_i, tx_load_i, tx_ready_o  transmit buffer load handshake
//   rx_data_o, rx_valid_o, rx_read_i  received byte, update pulse, consumer ack
//   busy_o, overrun_o                 byte in progress, sticky overrun
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              PCLK,
    input  logic              PRESET_n,
    input  logic              sclk_i,
    input  logic              ss_i,
    input  logic              mosi_i,
    output logic              miso_o,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              lsbfe_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_load_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_read_i,
    output logic              busy_o,
    output logic              overrun_o
);
    state_t                 state;
    logic [2:0]             cnt;
    logic [DATA_W-1:0]      tx_buf, tx_sr, rx_sr;
    logic                   rx_full, miso_q;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_lvl, sclk_chg, ss_lvl, ss_chg, mosi_lvl;
    logic                   smp_rise, sample_edge, shift_edge, ss_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
        .PCLK(PCLK), .PRESET_n(PRESET_n), .idle(cpol_i), .din(sclk_i),
        .level(sclk_lvl), .changed(sclk_chg)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss (
        .PCLK(PCLK), .PRESET_n(PRESET_n), .idle(1'b1), .din(ss_i),
        .level(ss_lvl), .changed(ss_chg)
    );

    // mosi needs no edge detect; same depth as sclk keeps the two aligned
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) mosi_sync <= '0;
        else mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
    end

    assign mosi_lvl    = mosi_sync[SYNC_STAGES-1];
    assign smp_rise    = SAMPLE_ON_RISE[{cpol_i, cpha_i}];
    assign sample_edge = sclk_chg & (sclk_lvl == smp_rise);
    assign shift_edge  = sclk_chg & (sclk_lvl != smp_rise);
    assign ss_fall     = ss_chg & ~ss_lvl;
    assign busy_o      = (state == ACTIVE);
    assign tx_ready_o  = ~busy_o;
    assign miso_o      = miso_q & ~ss_lvl;

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            state      <= IDLE;
            cnt        <= '0;
            tx_buf     <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
            rx_full    <= 1'b0;
            overrun_o  <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            rx_valid_o <= 1'b0;
            if (state != ACTIVE && tx_load_i) tx_buf <= tx_data_i;
            if (rx_read_i) rx_full <= 1'b0;
            case (state)
                IDLE: if (ss_fall) begin
                    state  <= ACTIVE;
                    cnt    <= '0;
                    // cpha=0 has no shift edge before the first sample, so the first bit goes out now
                    tx_sr  <= cpha_i ? tx_buf : drop_bit(tx_buf, lsbfe_i);
                    miso_q <= cpha_i ? 1'b0 : first_bit(tx_buf, lsbfe_i);
                end
                ACTIVE: if (ss_lvl) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    if (shift_edge) begin
                        miso_q <= first_bit(tx_sr, lsbfe_i);
                        tx_sr  <= drop_bit(tx_sr, lsbfe_i);
                    end
                    if (sample_edge) begin
                        rx_sr <= shift_in(rx_sr, mosi_lvl, lsbfe_i);
                        cnt   <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            state      <= DONE;
                            rx_data_o  <= shift_in(rx_sr, mosi_lvl, lsbfe_i);
                            rx_valid_o <= 1'b1;
                            rx_full    <= 1'b1;
                            if (rx_full && !rx_read_i) overrun_o <= 1'b1;
                        end
                    end
                end
                // reload keeps miso: with cpha=0 the pending trailing edge presents the new first bit
                DONE: begin
                    state <= ss_lvl ? IDLE : ACTIVE;
                    cnt   <= '0;
                    tx_sr <= tx_buf;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: randomized SPI master against a byte-level reference model
module tb_spi_slave_if;
    localparam int HALF = 8;

    logic       PCLK = 1'b0;
    logic       PRESET_n, sclk_i, ss_i, mosi_i, miso_o, cpol_i, cpha_i, lsbfe_i;
    logic [7:0] tx_data_i, rx_data_o;
    logic       tx_load_i, tx_ready_o, rx_valid_o, rx_read_i, busy_o, overrun_o;

    int         n_tests = 0, n_fail = 0, valid_cnt = 0;
    logic       auto_read = 1'b1, mid_load = 1'b0;
    logic [7:0] mid_val = 8'h00;
    logic [7:0] m_tx, m_rx;
    logic       m_full, m_ovr;
    logic [7:0] mo_q[$], mi_q[$];

    spi_slave_if #(.SYNC_STAGES(2)) dut (
        .PCLK(PCLK), .PRESET_n(PRESET_n), .sclk_i(sclk_i), .ss_i(ss_i), .mosi_i(mosi_i),
        .miso_o(miso_o), .cpol_i(cpol_i), .cpha_i(cpha_i), .lsbfe_i(lsbfe_i),
        .tx_data_i(tx_data_i), .tx_load_i(tx_load_i), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_read_i(rx_read_i),
        .busy_o(busy_o), .overrun_o(overrun_o)
    );

    always #5 PCLK = ~PCLK;

    // consumer: counts valid pulses and acknowledges each one when auto_read is set
    always @(negedge PCLK) begin
        rx_read_i = auto_read & rx_valid_o;
        if (rx_valid_o) valid_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic half();
        repeat (HALF) @(negedge PCLK);
    endtask

    task automatic model_reset();
        m_tx = 8'h00; m_rx = 8'h00; m_full = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic set_mode(input logic cpol, input logic cpha, input logic lsb);
        cpol_i = cpol; cpha_i = cpha; lsbfe_i = lsb; sclk_i = cpol;
        repeat (6) @(negedge PCLK);
    endtask

    task automatic load(input logic [7:0] v);
        check("load_ready", tx_ready_o, 1'b1);
        tx_data_i = v; tx_load_i = 1'b1;
        @(negedge PCLK);
        tx_load_i = 1'b0;
        m_tx = v;
    endtask

    // SPI master: drives nbits from mo_q, collects each full miso byte into mi_q
    task automatic frame(input int nbits, input bit hold);
        logic [7:0] cur, got;
        int k, idx;
        cur = '0; got = '0;
        ss_i = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            k = i % 8;
            idx = lsbfe_i ? k : 7 - k;
            if (k == 0) begin cur = mo_q.pop_front(); got = '0; end
            if (!cpha_i) begin
                mosi_i = cur[idx];
                half();
                got[idx] = miso_o;
                sclk_i = ~cpol_i;
                half();
                sclk_i = cpol_i;
            end else begin
                half();
                sclk_i = ~cpol_i;
                mosi_i = cur[idx];
                half();
                got[idx] = miso_o;
                sclk_i = cpol_i;
            end
            if (i == 1) check("busy_mid", {busy_o, tx_ready_o}, 2'b10);
            if (i == 3 && mid_load) begin
                tx_data_i = mid_val; tx_load_i = 1'b1;
                @(negedge PCLK);
                tx_load_i = 1'b0;
            end
            if (k == 7) mi_q.push_back(got);
        end
        if (!hold) begin
            half();
            ss_i = 1'b1; mosi_i = 1'b0;
            repeat (8) @(negedge PCLK);
        end
    endtask

    task automatic xfer(input string tag, input int nbits, input logic [7:0] d0, input logic [7:0] d1);
        int n_full, v0;
        logic [7:0] d;
        n_full = nbits / 8;
        v0 = valid_cnt;
        mo_q.delete(); mi_q.delete();
        mo_q.push_back(d0); mo_q.push_back(d1);
        frame(nbits, 1'b0);
        for (int j = 0; j < n_full; j++) begin
            d = (j == 0) ? d0 : d1;
            m_ovr = m_ovr | m_full;
            m_full = ~auto_read;
            m_rx = d;
            check({tag, "_miso"}, mi_q[j], m_tx);
        end
        check({tag, "_nvalid"}, valid_cnt - v0, n_full);
        check({tag, "_rx"}, rx_data_o, m_rx);
        check({tag, "_ovr"}, overrun_o, m_ovr);
        check({tag, "_idle"}, {busy_o, tx_ready_o, miso_o}, 3'b010);
    endtask

    initial begin
        PRESET_n = 1'b0; ss_i = 1'b1; sclk_i = 1'b0; mosi_i = 1'b0;
        cpol_i = 1'b0; cpha_i = 1'b0; lsbfe_i = 1'b0;
        tx_data_i = 8'h00; tx_load_i = 1'b0;
        model_reset();
        repeat (3) @(negedge PCLK);
        check("rst_rx", rx_data_o, 8'h00);
        check("rst_valid", rx_valid_o, 1'b0);
        check("rst_ovr", overrun_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_ready", tx_ready_o, 1'b1);
        check("rst_miso", miso_o, 1'b0);
        PRESET_n = 1'b1;
        repeat (4) @(negedge PCLK);

        set_mode(1'b0, 1'b0, 1'b1);
        load(8'h88);
        xfer("mode0_lsb", 8, 8'hAA, 8'h00);

        set_mode(1'b1, 1'b1, 1'b0);
        load(8'h18);
        xfer("mode3_msb", 8, 8'h33, 8'h00);

        set_mode(1'b0, 1'b1, 1'b0);
        xfer("abort", 3, 8'hE7, 8'h00);
        xfer("post_abort", 8, 8'h5A, 8'h00);

        PRESET_n = 1'b0; @(negedge PCLK); PRESET_n = 1'b1; model_reset();
        set_mode(1'b0, 1'b0, 1'b0);
        auto_read = 1'b0;
        xfer("b2b_noread", 16, 8'h11, 8'h22);
        PRESET_n = 1'b0; @(negedge PCLK); PRESET_n = 1'b1; model_reset();
        set_mode(1'b0, 1'b0, 1'b0);
        auto_read = 1'b1;
        xfer("b2b_read", 16, 8'h11, 8'h22);

        set_mode(1'b1, 1'b0, 1'b1);
        mo_q.delete(); mi_q.delete();
        mo_q.push_back(8'h9E);
        frame(4, 1'b1);
        PRESET_n = 1'b0;
        #1;
        check("mid_rst_rx", rx_data_o, 8'h00);
        check("mid_rst_flags", {rx_valid_o, overrun_o, busy_o, tx_ready_o, miso_o}, 5'b00010);
        ss_i = 1'b1; sclk_i = cpol_i; mosi_i = 1'b0;
        repeat (2) @(negedge PCLK);
        PRESET_n = 1'b1;
        model_reset();
        repeat (6) @(negedge PCLK);
        load(8'(($urandom & 32'hFF) | 32'h1));
        xfer("after_rst", 8, 8'hC3, 8'h00);

        set_mode(1'b0, 1'b1, 1'b1);
        load(8'h44);
        mid_load = 1'b1; mid_val = 8'h77;
        xfer("busy_load", 8, 8'h3C, 8'h00);
        mid_load = 1'b0;
        load(8'h77);
        xfer("idle_load", 8, 8'hA5, 8'h00);

        for (int it = 0; it < 40; it++) begin
            int r, nb;
            r = $urandom_range(0, 9);
            nb = (r < 2) ? $urandom_range(1, 7) : ((r < 6) ? 8 : 16);
            set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            auto_read = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) load(8'($urandom_range(0, 255)));
            xfer("rnd", nb, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_slave_if.md
SPI_SLAVE_IF -- requirements
Module: spi_slave_if

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth on sclk_i, ss_i and mosi_i (minimum 2).
REQ-002 PCLK  input  1  sole clock; all state updates on rising edge.
REQ-003 PRESET_n  input  1  asynchronous, active-low reset.
REQ-004 sclk_i  input  1  SPI serial clock from master; asynchronous to PCLK.
REQ-005 ss_i  input  1  slave select, active low; asynchronous.
REQ-006 mosi_i  input  1  master-out serial data; asynchronous.
REQ-007 miso_o  output  1  slave-out serial data.
REQ-008 cpol_i  input  1  clock idle level (0 = idle low).
REQ-009 cpha_i  input  1  0 = sample on leading edge; 1 = sample on trailing edge.
REQ-010 lsbfe_i  input  1  1 = LSB first; 0 = MSB first; applies to both directions.
REQ-011 tx_data_i  input  8  byte to return on miso.
REQ-012 tx_load_i  input  1  one-cycle strobe that latches tx_data_i.
REQ-013 tx_ready_o  output  1  high when tx_load_i is accepted.
REQ-014 rx_data_o  output  8  last complete received byte.
REQ-015 rx_valid_o  output  1  one-cycle pulse when rx_data_o updates.
REQ-016 rx_read_i  input  1  consumer acknowledge; clears rx_full.
REQ-017 busy_o  output  1  high while state is ACTIVE.
REQ-018 overrun_o  output  1  sticky error flag; cleared only by reset.

Function
REQ-019 sclk_i, ss_i and mosi_i shall pass through SYNC_STAGES flops; edge detection shall compare the last synchronized stage with one extra delayed flop.
REQ-020 Leading edge = rising when cpol_i=0, falling when cpol_i=1; trailing edge = the opposite edge.
REQ-021 Sample edge = leading when cpha_i=0, trailing when cpha_i=1; shift edge = the other edge.
REQ-022 States: IDLE (ss high), ACTIVE (shifting), DONE (one cycle, byte complete).
REQ-023 IDLE->ACTIVE on synchronized ss falling edge: load tx shift register from tx buffer, clear 3-bit counter, and present the first tx bit on miso_o the next cycle when cpha_i=0.
REQ-024 ACTIVE, sample edge: capture synchronized mosi into rx shift register per lsbfe_i; increment counter.
REQ-025 ACTIVE, shift edge: advance miso_o to next tx bit; with cpha_i=1, the first leading edge presents bit 0 of the order.
REQ-026 8th sample -> DONE: rx_data_o <= assembled byte, rx_valid_o=1 for one cycle, rx_full set; then ACTIVE if ss still low (reload tx buffer, counter 0), otherwise IDLE.
REQ-027 DONE with rx_full already set and no rx_read_i that cycle -> overrun_o=1; rx_data_o still overwritten.
REQ-028 rx_read_i and byte completion in the same cycle: rx_full stays set, no overrun.
REQ-029 ss rising edge mid-byte: abort to IDLE, counter cleared, no rx_valid_o, rx_data_o unchanged.
REQ-030 tx_ready_o = !busy_o; tx_load_i while busy is ignored; an unloaded buffer retransmits the last value (0x00 after reset).
REQ-031 miso_o = 0 whenever synchronized ss is high.
REQ-032 Sclk half-period shall be >= SYNC_STAGES+2 PCLK cycles; behaviour is undefined otherwise.
REQ-033 cpol_i, cpha_i and lsbfe_i shall be changed only in IDLE.

Reset
REQ-034 PRESET_n low -> immediately: state IDLE, synchronizers to idle (ss=1, sclk=cpol_i, mosi=0), all registers 0, miso_o=0, rx_valid_o=0, overrun_o=0, busy_o=0, tx_ready_o=1.
REQ-035 Reset asserted mid-transfer discards the partial byte; operation resumes only on the next ss falling edge after release.

Structure
REQ-036 Shared package spi_pkg: state encoding, DATA_W=8, and a mode constant mapping cpol/cpha to sample/shift edges.
REQ-037 One sub-module, spi_sync_edge: synchronizer plus rise/fall detector, instantiated for sclk and ss.

Verification
REQ-038 Mode 0, LSB first, tx 0x88, master sends 0xAA -> rx_data_o=0xAA, one rx_valid_o pulse, miso bits 0,0,0,1,0,0,0,1.
REQ-039 Mode 3, MSB first, tx 0x18, master sends 0x33 -> rx_data_o=0x33, miso bits 0,0,0,1,1,0,0,0.
REQ-040 ss high after 3 sclk cycles -> no rx_valid_o, busy_o=0, rx_data_o unchanged; next full byte 0x5A received correctly.
REQ-041 Two back-to-back bytes 0x11, 0x22 with no rx_read_i -> overrun_o=1 after 2nd byte, rx_data_o=0x22; the same sequence with rx_read_i on the 1st rx_valid_o -> overrun_o=0.
REQ-042 PRESET_n pulsed during bit 4 -> all outputs at reset values; next byte 0xC3 received intact.
REQ-043 tx_load_i 0x77 while busy -> ignored; current byte sends the old value, and 0x77 is accepted after return to IDLE.
